// File: rtl/hb_interp2.sv
// Two-times interpolating half-band FIR: each accepted sample yields a
// pass-through phase (x[n-2]) followed by a rounded, saturated midpoint phase.
module hb_interp2 #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PH0   = 2'd1,
        ST_PH1   = 2'd2
    } state_t;

    localparam logic signed [DW+5:0] SAT_MAX = {{7{1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [DW+5:0] SAT_MIN = {{7{1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW+5:0] RND     = {{(DW+2){1'b0}}, 4'b1000};

    state_t               state_q;
    logic signed [DW-1:0] d0_q, d1_q, d2_q, d3_q;
    logic signed [DW-1:0] d0_d, d1_d, d2_d, d3_d;
    logic [DW-1:0]        o_data_q;
    logic                 o_valid_q;

    logic                 accept_s;
    logic signed [DW:0]   sum_in_s;
    logic signed [DW:0]   sum_out_s;
    logic signed [DW+5:0] ext_in_s;
    logic signed [DW+5:0] ext_out_s;
    logic signed [DW+5:0] acc_s;
    logic signed [DW-1:0] p0_s;
    logic signed [DW-1:0] p1_s;

    function automatic logic signed [DW-1:0] sat_fn(input logic signed [DW+5:0] v);
        logic signed [DW+5:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[DW-1:0];
    endfunction

    assign o_ready  = !i_reset && ((state_q == ST_EMPTY) || ((state_q == ST_PH1) && i_ready));
    assign accept_s = i_valid && o_ready;
    assign o_data   = o_data_q;
    assign o_valid  = o_valid_q;

    // The new P0 is the post-shift d2, which is the current d1.
    assign p0_s = d1_q;

    // Odd phase: 9*(d1+d2) - (d0+d3), round half up, floor shift, clamp.
    always_comb begin
        sum_in_s  = {d1_q[DW-1], d1_q} + {d2_q[DW-1], d2_q};
        sum_out_s = {d0_q[DW-1], d0_q} + {d3_q[DW-1], d3_q};
        ext_in_s  = {{5{sum_in_s[DW]}}, sum_in_s};
        ext_out_s = {{5{sum_out_s[DW]}}, sum_out_s};
        acc_s     = (ext_in_s <<< 3) + ext_in_s - ext_out_s + RND;
        p1_s      = sat_fn(acc_s >>> 4);
    end

    // Delay line shifts only on an input accept.
    always_comb begin
        if (accept_s) begin
            d0_d = i_data;
            d1_d = d0_q;
            d2_d = d1_q;
            d3_d = d2_q;
        end else begin
            d0_d = d0_q;
            d1_d = d1_q;
            d2_d = d2_q;
            d3_d = d3_q;
        end
    end

    // Phase sequencer with registered output sample and valid.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_EMPTY;
            d0_q      <= {DW{1'b0}};
            d1_q      <= {DW{1'b0}};
            d2_q      <= {DW{1'b0}};
            d3_q      <= {DW{1'b0}};
            o_data_q  <= {DW{1'b0}};
            o_valid_q <= 1'b0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
            d3_q <= d3_d;
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_q   <= ST_PH0;
                        o_data_q  <= p0_s;
                        o_valid_q <= 1'b1;
                    end
                end
                ST_PH0: begin
                    if (i_ready) begin
                        state_q  <= ST_PH1;
                        o_data_q <= p1_s;
                    end
                end
                ST_PH1: begin
                    if (i_ready) begin
                        if (accept_s) begin
                            state_q  <= ST_PH0;
                            o_data_q <= p0_s;
                        end else begin
                            state_q   <= ST_EMPTY;
                            o_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_EMPTY;
                    o_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hb_interp2.sv
// Directed bench for hb_interp2: impulse, DC, saturation, backpressure,
// back-to-back rate and mid-stream reset against hand-computed streams.
module tb_hb_interp2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_data = 8'd0;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;

    int errors = 0;
    int checks = 0;

    hb_interp2 #(.DW(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_data", int'($signed(o_data)), 0);
        check("rst_ready", int'(o_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drives the inputs, collects every output transfer and compares the stream.
    task automatic run_seq(input string name, input int ins[$], input int exps[$], input bit bp);
        int  idx = 0;
        int  outs[$];
        int  cyc = 0;
        int  c0 = -1;
        bit  acc;
        bit  stall_prev = 1'b0;
        bit  pend = 1'b0;
        logic [7:0] data_prev = 8'd0;
        while ((idx < ins.size() || outs.size() < exps.size()) && cyc < 400) begin
            i_valid = (idx < ins.size());
            if (idx < ins.size()) begin
                i_data = 8'(ins[idx]);
            end else begin
                i_data = 8'd0;
            end
            i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = i_valid && o_ready;
            if (bp) begin
                if (stall_prev) begin
                    check({name, "_hold_data"}, int'($signed(o_data)), int'($signed(data_prev)));
                    check({name, "_hold_valid"}, int'(o_valid), 1);
                end
                if (pend) begin
                    check({name, "_ph0_ready"}, int'(o_ready), 0);
                end
            end else if (c0 >= 0) begin
                if (outs.size() < exps.size()) begin
                    check({name, "_valid_rate"}, int'(o_valid), 1);
                end
                if (idx < ins.size()) begin
                    check({name, "_ready_rate"}, int'(o_ready), ((cyc - c0) % 2 == 0) ? 1 : 0);
                end
            end
            if (o_valid && i_ready) begin
                outs.push_back(int'($signed(o_data)));
                pend = 1'b0;
            end
            if (acc) begin
                pend = 1'b1;
            end
            if (acc && c0 < 0) begin
                c0 = cyc;
            end
            stall_prev = o_valid && !i_ready;
            data_prev  = o_data;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
            end
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check({name, "_count"}, outs.size(), exps.size());
        for (int i = 0; i < exps.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), (i < outs.size()) ? outs[i] : -999, exps[i]);
        end
    endtask

    initial begin
        int in_q[$];
        int ex_q[$];

        do_reset();
        in_q = '{64, 0, 0, 0, 0};
        ex_q = '{0, -4, 0, 36, 64, 36, 0, -4, 0, 0};
        run_seq("impulse", in_q, ex_q, 1'b0);

        do_reset();
        in_q = '{100, 100, 100, 100, 100, 100, 100, 100};
        ex_q = '{0, -6, 0, 50, 100, 106, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
        run_seq("dc", in_q, ex_q, 1'b0);

        do_reset();
        in_q = '{-128, 127, 127, -128};
        ex_q = '{0, 8, 0, -80, -128, -8, 127, 127};
        run_seq("sat_hi", in_q, ex_q, 1'b0);

        do_reset();
        in_q = '{127, -128, -128, 127};
        ex_q = '{0, -8, 0, 79, 127, 7, -128, -128};
        run_seq("sat_lo", in_q, ex_q, 1'b0);

        do_reset();
        in_q = '{64, 0, 0, 0, 0};
        ex_q = '{0, -4, 0, 36, 64, 36, 0, -4, 0, 0};
        run_seq("backpr", in_q, ex_q, 1'b1);

        // Reset while a P1 is pending, then confirm the history was cleared.
        do_reset();
        i_valid = 1'b1;
        i_data  = 8'd64;
        i_ready = 1'b0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check("mid_ph1_data", int'($signed(o_data)), -4);
        check("mid_ph1_valid", int'(o_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_data", int'($signed(o_data)), 0);
        check("mid_rst_ready", int'(o_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_q = '{64};
        ex_q = '{0, -4};
        run_seq("post_rst", in_q, ex_q, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
